// File: rtl/maze_pkg.sv
// Shared constants for the maze access arbiter: tile geometry, probe offset,
// direction encodings and FSM state encoding.
package maze_pkg;

  localparam logic [10:0] TILE  = 11'd60;
  localparam logic [4:0]  ROWS  = 5'd8;
  localparam logic [4:0]  COLS  = 5'd8;
  localparam logic [9:0]  S_X   = 10'd0;
  localparam logic [9:0]  S_Y   = 10'd0;
  localparam logic [10:0] P_OFF = 11'd20;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0001;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef struct packed {
    logic dec_x;
    logic inc_x;
    logic dec_y;
    logic inc_y;
  } dir_offset_t;

  // Anything that is not exactly one-hot probes the sprite origin itself.
  function automatic dir_offset_t decode_dir(input logic [3:0] dir);
    dir_offset_t off;
    off = '{1'b0, 1'b0, 1'b0, 1'b0};
    case (dir)
      DIR_LEFT:  off.dec_x = 1'b1;
      DIR_RIGHT: off.inc_x = 1'b1;
      DIR_UP:    off.dec_y = 1'b1;
      DIR_DOWN:  off.inc_y = 1'b1;
      default:   off = '{1'b0, 1'b0, 1'b0, 1'b0};
    endcase
    return off;
  endfunction

endpackage

// File: rtl/tile_divider.sv
// Sequential divide-by-TILE by repeated subtraction: one subtraction per cycle,
// done stays high once the remainder has dropped below TILE.
module tile_divider
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] dividend,
  output logic [4:0]  quotient,
  output logic        done
);

  logic [10:0] rem_r;
  logic [4:0]  quo_r;
  logic        run_r;

  // Load on start, otherwise step the subtraction until the remainder fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= 11'd0;
      quo_r <= 5'd0;
      run_r <= 1'b0;
    end else if (start) begin
      rem_r <= dividend;
      quo_r <= 5'd0;
      run_r <= 1'b1;
    end else if (run_r && (rem_r >= TILE)) begin
      rem_r <= rem_r - TILE;
      quo_r <= quo_r + 5'd1;
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      run_r <= run_r;
    end
  end

  assign quotient = quo_r;
  assign done     = run_r && (rem_r < TILE);

endmodule

// File: rtl/maze_access_arbiter.sv
// Round-robin arbiter that turns sprite position/direction into a maze wall lookup.
// Optional horizontal wrap on TUNNEL_ROW is enabled by defining MAZE_TUNNEL_EN.
module maze_access_arbiter
  import maze_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TUNNEL_ROW = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [10*NUM_REQ-1:0]   xpos_bus,
  input  logic [10*NUM_REQ-1:0]   ypos_bus,
  input  logic [4*NUM_REQ-1:0]    dir_bus,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    blocked,
  output logic [3:0]              row,
  output logic [3:0]              col,
  output logic [5:0]              maze_addr,
  output logic                    maze_rd,
  input  logic                    maze_data,
  output logic                    busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef MAZE_TUNNEL_EN
  localparam logic TUNNEL_ON = 1'b1;
`else
  localparam logic TUNNEL_ON = 1'b0;
`endif

  logic [2:0]         state_r;
  logic [IDX_W-1:0]   rr_ptr_r, gnt_r;
  logic               neg_x_r, pend_oob_r;
  logic [3:0]         pend_row_r, pend_col_r;
  logic [NUM_REQ-1:0] ack_r;
  logic               maze_rd_r, blocked_r;
  logic [5:0]         maze_addr_r;
  logic [3:0]         row_r, col_r;

  logic [IDX_W-1:0]   gnt_s, rr_next_s;
  logic               gnt_vld_s, neg_resp_s, start_s, tunnel_hit_s, oob_s;
  logic [9:0]         x_s, y_s;
  logic [3:0]         dir_s, res_row_s, res_col_s;
  dir_offset_t        off_s;
  logic [10:0]        px_s, py_s, div_x_s;
  logic [4:0]         row_q_s, col_q_s;
  logic               done_x_s, done_y_s;
  logic [5:0]         res_addr_s;

  // Lowest requesting index at or after rr_ptr wins.
  always_comb begin
    gnt_s     = '0;
    gnt_vld_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld_s && req[(32'(rr_ptr_r) + 32'(k)) % NUM_REQ]) begin
        gnt_vld_s = 1'b1;
        gnt_s     = IDX_W'((32'(rr_ptr_r) + 32'(k)) % NUM_REQ);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    rr_next_s = (gnt_s == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_s + IDX_W'(1);
  end

  // Probe point in 11-bit two's complement; bit 10 is the sign.
  always_comb begin
    x_s   = xpos_bus[10*gnt_s +: 10];
    y_s   = ypos_bus[10*gnt_s +: 10];
    dir_s = dir_bus[4*gnt_s +: 4];
    off_s = decode_dir(dir_s);
    px_s  = {1'b0, x_s} - {1'b0, S_X};
    py_s  = {1'b0, y_s} - {1'b0, S_Y};
    px_s  = off_s.dec_x ? px_s - P_OFF : (off_s.inc_x ? px_s + P_OFF : px_s);
    py_s  = off_s.dec_y ? py_s - P_OFF : (off_s.inc_y ? py_s + P_OFF : py_s);
    neg_resp_s = py_s[10] || (px_s[10] && !TUNNEL_ON);
    div_x_s    = px_s[10] ? 11'd0 : px_s;
    start_s    = (state_r == ST_IDLE) && gnt_vld_s && !neg_resp_s;
  end

  tile_divider u_div_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .dividend (div_x_s),
    .quotient (col_q_s),
    .done     (done_x_s)
  );

  tile_divider u_div_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .dividend (py_s),
    .quotient (row_q_s),
    .done     (done_y_s)
  );

  // Resolve the probed tile, bounds and tunnel wrap from the final quotients.
  always_comb begin
    tunnel_hit_s = TUNNEL_ON && (row_q_s == 5'(TUNNEL_ROW));
    res_row_s    = row_q_s[3:0];
    res_col_s    = col_q_s[3:0];
    oob_s        = (row_q_s >= ROWS) || (col_q_s >= COLS);
    if (neg_x_r) begin
      if (tunnel_hit_s) begin
        res_col_s = 4'(COLS - 5'd1);
        oob_s     = 1'b0;
      end else begin
        res_row_s = 4'd0;
        res_col_s = 4'd0;
        oob_s     = 1'b1;
      end
    end else if (tunnel_hit_s && (col_q_s >= COLS)) begin
      res_col_s = 4'd0;
      oob_s     = (row_q_s >= ROWS);
    end else begin
      oob_s = oob_s;
    end
    res_addr_s = 6'(res_row_s) * 6'(COLS) + 6'(res_col_s);
  end

  // Lookup FSM; results only change on the edge that enters RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      gnt_r       <= '0;
      neg_x_r     <= 1'b0;
      pend_oob_r  <= 1'b0;
      pend_row_r  <= 4'd0;
      pend_col_r  <= 4'd0;
      ack_r       <= '0;
      maze_rd_r   <= 1'b0;
      maze_addr_r <= 6'd0;
      blocked_r   <= 1'b0;
      row_r       <= 4'd0;
      col_r       <= 4'd0;
    end else begin
      ack_r     <= '0;
      maze_rd_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_vld_s) begin
            gnt_r    <= gnt_s;
            rr_ptr_r <= rr_next_s;
            if (neg_resp_s) begin
              blocked_r <= 1'b1;
              row_r     <= 4'd0;
              col_r     <= 4'd0;
              ack_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_s;
              state_r   <= ST_RESP;
            end else begin
              neg_x_r <= px_s[10];
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (done_x_s && done_y_s) begin
            pend_row_r <= res_row_s;
            pend_col_r <= res_col_s;
            pend_oob_r <= oob_s;
            if (!oob_s) begin
              maze_rd_r   <= 1'b1;
              maze_addr_r <= res_addr_s;
            end else begin
              maze_addr_r <= maze_addr_r;
            end
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_CHECK: begin
          if (pend_oob_r) begin
            blocked_r <= 1'b1;
            row_r     <= pend_row_r;
            col_r     <= pend_col_r;
            ack_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_r;
            state_r   <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          blocked_r <= maze_data;
          row_r     <= pend_row_r;
          col_r     <= pend_col_r;
          ack_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_r;
          state_r   <= ST_RESP;
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign ack       = ack_r;
  assign maze_rd   = maze_rd_r;
  assign maze_addr = maze_addr_r;
  assign blocked   = blocked_r;
  assign row       = row_r;
  assign col       = col_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_maze_access_arbiter.sv
// Directed bench for maze_access_arbiter with a model wall ROM; honours MAZE_TUNNEL_EN.
module tb_maze_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [39:0] xpos_bus = 40'd0;
  logic [39:0] ypos_bus = 40'd0;
  logic [15:0] dir_bus = 16'd0;
  logic [3:0]  ack;
  logic        blocked;
  logic [3:0]  row, col;
  logic [5:0]  maze_addr;
  logic        maze_rd;
  logic        maze_data = 1'b0;
  logic        busy;

  logic        rom [64];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  logic [5:0]  last_addr = 6'd0;

  always #5 clk = ~clk;

  maze_access_arbiter #(.NUM_REQ(4), .TUNNEL_ROW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .xpos_bus  (xpos_bus),
    .ypos_bus  (ypos_bus),
    .dir_bus   (dir_bus),
    .ack       (ack),
    .blocked   (blocked),
    .row       (row),
    .col       (col),
    .maze_addr (maze_addr),
    .maze_rd   (maze_rd),
    .maze_data (maze_data),
    .busy      (busy)
  );

  always @(posedge clk) maze_data <= maze_rd ? rom[maze_addr] : 1'b0;

  always @(negedge clk) begin
    if (maze_rd === 1'b1) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= maze_addr;
    end
  end

  task automatic set_slot(input int i, input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
    xpos_bus[10*i +: 10] = x;
    ypos_bus[10*i +: 10] = y;
    dir_bus[4*i +: 4]    = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic lookup(input string name, input int idx, input logic [9:0] x, input logic [9:0] y,
                        input logic [3:0] dir, input int exp_d, input logic exp_blk,
                        input logic [3:0] exp_row, input logic [3:0] exp_col,
                        input int exp_rd, input logic [5:0] exp_addr);
    int         rd0, d;
    logic       got;
    logic [3:0] ack_seen, exp_ack;
    set_slot(idx, x, y, dir);
    exp_ack  = 4'b0001 << idx;
    rd0      = rd_cnt;
    got      = 1'b0;
    d        = 0;
    ack_seen = 4'b0;
    req[idx] = 1'b1;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, busy); end
      end
      if (ack !== 4'b0) begin got = 1'b1; d = k; ack_seen = ack; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL %s timeout: no ack within 40 cycles", name); end
    checks++;
    if (ack_seen !== exp_ack) begin errors++; $display("FAIL %s ack: got %b want %b", name, ack_seen, exp_ack); end
    checks++;
    if (d != exp_d) begin errors++; $display("FAIL %s latency: got G+%0d want G+%0d", name, d, exp_d); end
    checks++;
    if (blocked !== exp_blk) begin errors++; $display("FAIL %s blocked: got %b want %b", name, blocked, exp_blk); end
    checks++;
    if (row !== exp_row) begin errors++; $display("FAIL %s row: got %0d want %0d", name, row, exp_row); end
    checks++;
    if (col !== exp_col) begin errors++; $display("FAIL %s col: got %0d want %0d", name, col, exp_col); end
    req[idx] = 1'b0;
    #1;
    checks++;
    if (rd_cnt - rd0 != exp_rd) begin errors++; $display("FAIL %s maze_rd count: got %0d want %0d", name, rd_cnt - rd0, exp_rd); end
    if (exp_rd != 0) begin
      checks++;
      if (last_addr !== exp_addr) begin errors++; $display("FAIL %s maze_addr: got %0d want %0d", name, last_addr, exp_addr); end
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0 || row !== exp_row || col !== exp_col || blocked !== exp_blk) begin
      errors++;
      $display("FAIL %s hold: ack=%b blk=%b row=%0d col=%0d want ack=0000 blk=%b row=%0d col=%0d",
               name, ack, blocked, row, col, exp_blk, exp_row, exp_col);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 4'b0 || maze_rd !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset ctrl: ack=%b maze_rd=%b busy=%b want 0000/0/0", ack, maze_rd, busy);
    end
    checks++;
    if (maze_addr !== 6'd0 || blocked !== 1'b0 || row !== 4'd0 || col !== 4'd0) begin
      errors++; $display("FAIL reset data: addr=%0d blk=%b row=%0d col=%0d want 0", maze_addr, blocked, row, col);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lookups();
    lookup("right_wall", 0, 10'd130, 10'd70, 4'b0010, 6, 1'b1, 4'd1, 4'd2, 1, 6'd10);
`ifdef MAZE_TUNNEL_EN
    lookup("neg_x", 1, 10'd10, 10'd70, 4'b1000, 4, 1'b1, 4'd0, 4'd0, 0, 6'd0);
`else
    lookup("neg_x", 1, 10'd10, 10'd70, 4'b1000, 1, 1'b1, 4'd0, 4'd0, 0, 6'd0);
`endif
    lookup("none_open", 2, 10'd70, 10'd70, 4'b0000, 5, 1'b0, 4'd1, 4'd1, 1, 6'd9);
    lookup("up_open", 3, 10'd100, 10'd130, 4'b0100, 5, 1'b0, 4'd1, 4'd1, 1, 6'd9);
    lookup("down_wall", 0, 10'd40, 10'd100, 4'b0001, 6, 1'b1, 4'd2, 4'd0, 1, 6'd16);
    lookup("non_onehot", 1, 10'd110, 10'd70, 4'b0110, 5, 1'b0, 4'd1, 4'd1, 1, 6'd9);
  endtask

  task automatic test_tunnel();
`ifdef MAZE_TUNNEL_EN
    lookup("tunnel_right", 2, 10'd470, 10'd200, 4'b0010, 12, 1'b0, 4'd3, 4'd0, 1, 6'd24);
    lookup("tunnel_left", 3, 10'd10, 10'd200, 4'b1000, 7, 1'b1, 4'd3, 4'd7, 1, 6'd31);
`else
    lookup("tunnel_right", 2, 10'd470, 10'd200, 4'b0010, 11, 1'b1, 4'd3, 4'd8, 0, 6'd0);
    lookup("tunnel_left", 3, 10'd10, 10'd200, 4'b1000, 1, 1'b1, 4'd0, 4'd0, 0, 6'd0);
`endif
  endtask

  task automatic test_bounds();
    lookup("last_row", 0, 10'd0, 10'd479, 4'b0000, 11, 1'b1, 4'd7, 4'd0, 1, 6'd56);
    lookup("row_oob", 1, 10'd0, 10'd480, 4'b0000, 11, 1'b1, 4'd8, 4'd0, 0, 6'd0);
  endtask

  task automatic test_reset_mid();
    int acks, d;
    set_slot(0, 10'd470, 10'd200, 4'b0010);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid busy before reset: got %b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0 || maze_rd !== 1'b0 || busy !== 1'b0 || maze_addr !== 6'd0 ||
        blocked !== 1'b0 || row !== 4'd0 || col !== 4'd0) begin
      errors++;
      $display("FAIL mid reset outputs: ack=%b rd=%b busy=%b addr=%0d blk=%b row=%0d col=%0d want all 0",
               ack, maze_rd, busy, maze_addr, blocked, row, col);
    end
    req = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack !== 4'b0) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL mid stale ack: got %0d acks want 0", acks); end
    set_slot(0, 10'd10, 10'd10, 4'b0000);
    set_slot(1, 10'd10, 10'd10, 4'b0000);
    req = 4'b0011;
    d = 0;
    for (int k = 1; k <= 20 && d == 0; k++) begin
      @(negedge clk);
      if (ack !== 4'b0) d = k;
    end
    checks++;
    if (ack !== 4'b0001 || d != 4) begin
      errors++; $display("FAIL mid regrant: ack=%b at G+%0d want 0001 at G+4", ack, d);
    end
    req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_a [5] = '{0, 1, 2, 3, 0};
    int exp_b [7] = '{0, 1, 2, 3, 0, 2, 0};
    int cnt, last;
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 10'd10, 10'd10, 4'b0000);
    req = 4'b1111;
    cnt = 0; last = 0;
    for (int k = 1; k <= 100 && cnt < 5; k++) begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        want = 4'b0001 << exp_a[cnt];
        checks++;
        if (ack !== want) begin errors++; $display("FAIL rr_a ack%0d: got %b want %b", cnt, ack, want); end
        checks++;
        if (k - last != ((cnt == 0) ? 4 : 5)) begin
          errors++; $display("FAIL rr_a gap%0d: got %0d want %0d", cnt, k - last, (cnt == 0) ? 4 : 5);
        end
        last = k;
        cnt++;
      end
    end
    req = 4'b0;
    checks++;
    if (cnt != 5) begin errors++; $display("FAIL rr_a count: got %0d want 5", cnt); end
    do_reset();
    req = 4'b1111;
    cnt = 0;
    for (int k = 1; k <= 100 && cnt < 7; k++) begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        want = 4'b0001 << exp_b[cnt];
        checks++;
        if (ack !== want) begin errors++; $display("FAIL rr_b ack%0d: got %b want %b", cnt, ack, want); end
        if (cnt == 3) req = 4'b0101;
        cnt++;
      end
    end
    req = 4'b0;
    checks++;
    if (cnt != 7) begin errors++; $display("FAIL rr_b count: got %0d want 7", cnt); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 1'b0;
    rom[10] = 1'b1;
    rom[16] = 1'b1;
    rom[31] = 1'b1;
    rom[56] = 1'b1;
    test_reset();
    test_lookups();
    test_tunnel();
    test_bounds();
    test_reset_mid();
    test_round_robin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
